bipbip_enc_ctrl: RTL and testbench

Encryption-direction sequencer for the BipBip 24-bit pointer cipher; it is the counterpart to the decryption path that consumes `tweak_word`/`block_word` pairs. It accepts plaintext+tweak requests and regenerates the 12-entry tweak schedule only when the tweak changes. It drives an external combinational round datapath one round per cycle and returns the ciphertext. It also caches the last encryption pair so that repeated requests complete in one cycle.

---
 rtl/bipbip_enc_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_bipbip_enc_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bipbip_enc_ctrl.sv
// bipbip_enc_ctrl
// Encryption-direction sequencer for the BipBip 24-bit pointer cipher.
// It accepts plaintext+tweak requests. It regenerates the NUM_ROUNDS-entry tweak
// schedule only when the tweak changes. It steps an external combinational round
// datapath one round per cycle and returns the ciphertext. The last completed
// (plain, tweak, cipher) triple is cached, so a repeated request is answered
// one cycle after it is accepted.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   key_valid_i         key schedule loaded and stable (level)
//   req_*               request handshake: plaintext and tweak in
//   rsp_*               response handshake: ciphertext out, cache-hit flag
//   ts_tweak_o/ts_idx_o address presented to the external tweak-schedule function
//   ts_word_i           schedule word for (ts_tweak_o, ts_idx_o), combinational
//   rnd_state_o/rnd_idx_o/rnd_tkey_o
//                       round input, round index and tweak round word
//   rnd_state_i         round output, combinational
module bipbip_enc_ctrl #(
   parameter int unsigned NUM_ROUNDS = 12,
   parameter int unsigned BLOCK_W    = 32,
   parameter int unsigned TWEAK_W    = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               key_valid_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [BLOCK_W-1:0] req_plain_i,
   input  logic [TWEAK_W-1:0] req_tweak_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [BLOCK_W-1:0] rsp_cipher_o,
   output logic               rsp_hit_o,
   output logic [TWEAK_W-1:0] ts_tweak_o,
   output logic [3:0]         ts_idx_o,
   input  logic [BLOCK_W-1:0] ts_word_i,
   output logic [BLOCK_W-1:0] rnd_state_o,
   output logic [3:0]         rnd_idx_o,
   output logic [BLOCK_W-1:0] rnd_tkey_o,
   input  logic [BLOCK_W-1:0] rnd_state_i
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      TSCHED,
      ROUND,
      RESP
   } state_t;

   state_t state_q, state_d;

   logic [3:0]         idx;
   logic [BLOCK_W-1:0] state_reg;
   logic [TWEAK_W-1:0] cur_tweak;
   logic [BLOCK_W-1:0] ts_reg [NUM_ROUNDS];
   logic               ts_valid;

   logic [BLOCK_W-1:0] c_plain;
   logic [TWEAK_W-1:0] c_tweak;
   logic [BLOCK_W-1:0] c_cipher;
   logic               c_valid;

   logic accept;
   logic cache_hit;
   logic tweak_reuse;
   logic last_idx;

   assign cache_hit   = c_valid && (req_plain_i == c_plain) && (req_tweak_i == c_tweak);
   assign tweak_reuse = ts_valid && (req_tweak_i == cur_tweak);
   assign last_idx    = (idx == LAST_IDX);

   assign ts_tweak_o  = cur_tweak;
   assign ts_idx_o    = idx;
   assign rnd_idx_o   = idx;
   assign rnd_state_o = state_reg;
   assign rnd_tkey_o  = ts_reg[idx];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      accept      = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = key_valid_i;
            accept      = req_valid_i && key_valid_i;
            if (accept) begin
               if (cache_hit) begin
                  state_d = RESP;
               end else if (tweak_reuse) begin
                  state_d = ROUND;
               end else begin
                  state_d = TSCHED;
               end
            end
         end
         TSCHED: begin
            if (!key_valid_i) begin
               state_d = IDLE;
            end else if (last_idx) begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (!key_valid_i) begin
               state_d = IDLE;
            end else if (last_idx) begin
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx          <= '0;
         state_reg    <= '0;
         cur_tweak    <= '0;
         ts_valid     <= 1'b0;
         c_plain      <= '0;
         c_tweak      <= '0;
         c_cipher     <= '0;
         c_valid      <= 1'b0;
         rsp_cipher_o <= '0;
         rsp_hit_o    <= 1'b0;
         for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
            ts_reg[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (cache_hit) begin
                     rsp_cipher_o <= c_cipher;
                     rsp_hit_o    <= 1'b1;
                  end else begin
                     // c_plain is overwritten here, so the cache must be
                     // invalid until this encryption completes.
                     c_plain   <= req_plain_i;
                     c_valid   <= 1'b0;
                     state_reg <= req_plain_i;
                     idx       <= '0;
                     if (!tweak_reuse) begin
                        cur_tweak <= req_tweak_i;
                        ts_valid  <= 1'b0;
                     end
                  end
               end
            end
            TSCHED: begin
               if (key_valid_i) begin
                  ts_reg[idx] <= ts_word_i;
                  if (last_idx) begin
                     idx      <= '0;
                     ts_valid <= 1'b1;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end
            ROUND: begin
               if (key_valid_i) begin
                  state_reg <= rnd_state_i;
                  if (last_idx) begin
                     idx          <= '0;
                     rsp_cipher_o <= rnd_state_i;
                     rsp_hit_o    <= 1'b0;
                     c_tweak      <= cur_tweak;
                     c_cipher     <= rnd_state_i;
                     c_valid      <= 1'b1;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end
            default: ;
         endcase
         // Key loss invalidates everything derived from the key; placed last so
         // it overrides any load made on the same edge.
         if (!key_valid_i) begin
            c_valid  <= 1'b0;
            ts_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bipbip_enc_ctrl.sv
// tb_bipbip_enc_ctrl
// Directed bench for bipbip_enc_ctrl. The external functions are modelled as
// ts_word = ts_idx + 1 and round_out = round_in + tkey. With these models the
// ciphertext is plain + 0x4E, which is plain + (1 + 2 + ... + 12).
module tb_bipbip_enc_ctrl;

   logic        clk;
   logic        rst;
   logic        key_valid;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_plain;
   logic [63:0] req_tweak;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_cipher;
   logic        rsp_hit;
   logic [63:0] ts_tweak;
   logic [3:0]  ts_idx;
   logic [31:0] ts_word;
   logic [31:0] rnd_state_out;
   logic [3:0]  rnd_idx;
   logic [31:0] rnd_tkey;
   logic [31:0] rnd_state_in;

   int checks = 0;
   int errors = 0;

   bipbip_enc_ctrl #(
      .NUM_ROUNDS(12),
      .BLOCK_W   (32),
      .TWEAK_W   (64)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .key_valid_i (key_valid),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_plain_i (req_plain),
      .req_tweak_i (req_tweak),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_cipher_o(rsp_cipher),
      .rsp_hit_o   (rsp_hit),
      .ts_tweak_o  (ts_tweak),
      .ts_idx_o    (ts_idx),
      .ts_word_i   (ts_word),
      .rnd_state_o (rnd_state_out),
      .rnd_idx_o   (rnd_idx),
      .rnd_tkey_o  (rnd_tkey),
      .rnd_state_i (rnd_state_in)
   );

   assign ts_word      = {28'd0, ts_idx} + 32'd1;
   assign rnd_state_in = rnd_state_out + rnd_tkey;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a request and let the accept edge happen; returns in cycle 1.
   task automatic issue(input logic [31:0] p, input logic [63:0] t, output logic rdy);
      req_plain = p;
      req_tweak = t;
      req_valid = 1'b1;
      #1;
      rdy = req_ready;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Bounded wait for rsp_valid; lat is the cycle number it appeared in.
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_req_ready got %b want 1", req_ready);
      end
      checks++;
      if (rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_cipher !== 32'd0) begin
         errors++;
         $display("FAIL reset_rsp got v=%b h=%b c=%h want 0/0/0", rsp_valid, rsp_hit, rsp_cipher);
      end
      checks++;
      if (ts_idx !== 4'd0 || rnd_idx !== 4'd0 || ts_tweak !== 64'd0 ||
          rnd_state_out !== 32'd0 || rnd_tkey !== 32'd0) begin
         errors++;
         $display("FAIL reset_ts_rnd got idx=%0d/%0d tw=%h st=%h tk=%h want all 0",
                  ts_idx, rnd_idx, ts_tweak, rnd_state_out, rnd_tkey);
      end
   endtask

   task automatic test_new_tweak();
      logic rdy;
      int   k;
      issue(32'h0000_1000, 64'hA5, rdy);
      checks++;
      if (rdy !== 1'b1) begin
         errors++;
         $display("FAIL new_tweak_ready got %b want 1", rdy);
      end
      checks++;
      if (ts_tweak !== 64'hA5) begin
         errors++;
         $display("FAIL new_tweak_ts_tweak got %h want a5", ts_tweak);
      end
      k = 1;
      while (rsp_valid !== 1'b1 && k < 60) begin
         if (k <= 12) begin
            checks++;
            if (ts_idx !== 4'(k - 1)) begin
               errors++;
               $display("FAIL tsched_idx cycle %0d got %0d want %0d", k, ts_idx, k - 1);
            end
         end else if (k <= 24) begin
            checks++;
            if (rnd_idx !== 4'(k - 13)) begin
               errors++;
               $display("FAIL round_idx cycle %0d got %0d want %0d", k, rnd_idx, k - 13);
            end
         end
         @(posedge clk);
         #1;
         k++;
      end
      checks++;
      if (k != 25) begin
         errors++;
         $display("FAIL new_tweak_latency got %0d want 25", k);
      end
      checks++;
      if (rsp_cipher !== 32'h0000_104E || rsp_hit !== 1'b0) begin
         errors++;
         $display("FAIL new_tweak_rsp got c=%h h=%b want 0000104e/0", rsp_cipher, rsp_hit);
      end
      handshake();
   endtask

   task automatic test_tweak_reuse();
      logic rdy;
      int   lat;
      issue(32'hFFFF_FFF0, 64'hA5, rdy);
      checks++;
      if (rnd_idx !== 4'd0 || rnd_state_out !== 32'hFFFF_FFF0) begin
         errors++;
         $display("FAIL reuse_first_round got idx=%0d st=%h want 0/fffffff0", rnd_idx, rnd_state_out);
      end
      wait_rsp(lat);
      checks++;
      if (lat != 13) begin
         errors++;
         $display("FAIL reuse_latency got %0d want 13", lat);
      end
      checks++;
      if (rsp_cipher !== 32'h0000_003E || rsp_hit !== 1'b0) begin
         errors++;
         $display("FAIL reuse_rsp got c=%h h=%b want 0000003e/0", rsp_cipher, rsp_hit);
      end
      handshake();
   endtask

   task automatic test_cache_hit();
      logic rdy;
      int   lat;
      issue(32'hFFFF_FFF0, 64'hA5, rdy);
      wait_rsp(lat);
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL hit_latency got %0d want 1", lat);
      end
      checks++;
      if (rsp_cipher !== 32'h0000_003E || rsp_hit !== 1'b1) begin
         errors++;
         $display("FAIL hit_rsp got c=%h h=%b want 0000003e/1", rsp_cipher, rsp_hit);
      end
      handshake();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL hit_after_handshake got v=%b want 0", rsp_valid);
      end
   endtask

   task automatic test_backpressure();
      logic rdy;
      int   lat;
      issue(32'hFFFF_FFF0, 64'hA5, rdy);
      // A different request stays pending throughout the stalled response.
      req_plain = 32'h0000_0100;
      req_tweak = 64'hA5;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_cipher !== 32'h0000_003E || rsp_hit !== 1'b1 ||
             req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cycle %0d got v=%b c=%h h=%b rdy=%b want 1/0000003e/1/0",
                     i, rsp_valid, rsp_cipher, rsp_hit, req_ready);
         end
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_release got v=%b rdy=%b want 0/1", rsp_valid, req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_rsp(lat);
      checks++;
      if (lat != 13 || rsp_cipher !== 32'h0000_014E || rsp_hit !== 1'b0) begin
         errors++;
         $display("FAIL pending_req got lat=%0d c=%h h=%b want 13/0000014e/0", lat, rsp_cipher, rsp_hit);
      end
      handshake();
   endtask

   task automatic test_key_loss();
      logic rdy;
      int   lat;
      logic seen;
      issue(32'h0000_2000, 64'hA5, rdy);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (rnd_idx !== 4'd4) begin
         errors++;
         $display("FAIL keyloss_round_pos got %0d want 4", rnd_idx);
      end
      key_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         checks++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL keyloss_idle got v=%b rdy=%b want 0/0", rsp_valid, req_ready);
         end
      end
      key_valid = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL keyloss_no_rsp got %b want 0", seen);
      end
      issue(32'h0000_0100, 64'hA5, rdy);
      wait_rsp(lat);
      checks++;
      if (lat != 25 || rsp_cipher !== 32'h0000_014E || rsp_hit !== 1'b0) begin
         errors++;
         $display("FAIL keyloss_refill got lat=%0d c=%h h=%b want 25/0000014e/0", lat, rsp_cipher, rsp_hit);
      end
      handshake();
   endtask

   task automatic test_reset_mid();
      logic rdy;
      int   lat;
      issue(32'h0000_3000, 64'hB6, rdy);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (ts_idx !== 4'd2) begin
         errors++;
         $display("FAIL rstmid_pos got %0d want 2", ts_idx);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_cipher !== 32'd0 || rsp_hit !== 1'b0 ||
          ts_idx !== 4'd0 || ts_tweak !== 64'd0 || rnd_state_out !== 32'd0 || rnd_tkey !== 32'd0) begin
         errors++;
         $display("FAIL rstmid_outputs got rdy=%b v=%b c=%h h=%b idx=%0d tw=%h st=%h tk=%h",
                  req_ready, rsp_valid, rsp_cipher, rsp_hit, ts_idx, ts_tweak, rnd_state_out, rnd_tkey);
      end
      issue(32'h0000_3000, 64'hB6, rdy);
      wait_rsp(lat);
      checks++;
      if (lat != 25 || rsp_cipher !== 32'h0000_304E || rsp_hit !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_next got lat=%0d c=%h h=%b want 25/0000304e/0", lat, rsp_cipher, rsp_hit);
      end
      handshake();
   endtask

   task automatic test_back_to_back();
      int n_rsp;
      logic bad;
      n_rsp = 0;
      bad   = 1'b0;
      req_plain = 32'h0000_3000;
      req_tweak = 64'hB6;
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (rsp_valid === 1'b1) begin
            n_rsp++;
            if (rsp_hit !== 1'b1 || rsp_cipher !== 32'h0000_304E) bad = 1'b1;
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      checks++;
      if (n_rsp != 4) begin
         errors++;
         $display("FAIL b2b_count got %0d want 4", n_rsp);
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL b2b_data got bad=%b want 0", bad);
      end
   endtask

   initial begin
      rst       = 1'b1;
      key_valid = 1'b1;
      req_valid = 1'b0;
      req_plain = '0;
      req_tweak = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_new_tweak();
      test_tweak_reuse();
      test_cache_hit();
      test_backpressure();
      test_key_loss();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
